// File: rtl/ccis_host_mem_pkg.sv
// Shared types for the CCI-S host memory responder: channel structs, FIFO entry
// structs, memory line type and default parameter values.
package ccis_host_mem_pkg;

    localparam int unsigned CCIS_CL_WIDTH          = 512;
    localparam int unsigned CCIS_ADDR_WIDTH        = 32;
    localparam int unsigned CCIS_MDATA_WIDTH       = 16;

    localparam int unsigned DEFAULT_ADDR_WIDTH     = 10;
    localparam int unsigned DEFAULT_READ_LATENCY   = 2;
    localparam int unsigned DEFAULT_FIFO_DEPTH     = 16;
    localparam int unsigned DEFAULT_ALM_FULL_SLACK = 4;

    typedef logic [CCIS_CL_WIDTH-1:0]    t_mem_line;
    typedef logic [CCIS_ADDR_WIDTH-1:0]  t_ccis_addr;
    typedef logic [CCIS_MDATA_WIDTH-1:0] t_ccis_mdata;

    typedef struct packed {
        logic [11:0] rsvd;
        logic [3:0]  req_type;
        t_ccis_addr  addr;
        t_ccis_mdata mdata;
    } t_ccis_req_hdr;

    typedef struct packed {
        logic [7:0]  rsvd;
        t_ccis_mdata mdata;
    } t_ccis_rsp_hdr;

    typedef struct packed {
        t_ccis_req_hdr hdr;
        logic          rdValid;
    } t_if_ccis_c0_Tx;

    typedef struct packed {
        t_ccis_req_hdr hdr;
        t_mem_line     data;
        logic          wrValid;
        logic          intrValid;
    } t_if_ccis_c1_Tx;

    typedef struct packed {
        t_ccis_rsp_hdr hdr;
        t_mem_line     data;
        logic          wrValid;
        logic          rdValid;
        logic          cfgValid;
        logic          umsgValid;
        logic          intrValid;
    } t_if_ccis_c0_Rx;

    typedef struct packed {
        t_ccis_rsp_hdr hdr;
        logic          wrValid;
        logic          intrValid;
    } t_if_ccis_c1_Rx;

    typedef struct packed {
        t_ccis_addr  addr;
        t_ccis_mdata mdata;
    } t_read_req;

    typedef struct packed {
        t_ccis_addr  addr;
        t_ccis_mdata mdata;
        t_mem_line   data;
    } t_write_req;

    typedef struct packed {
        logic        valid;
        t_ccis_mdata mdata;
        t_mem_line   data;
    } t_rd_pipe;

endpackage

// File: rtl/ccis_host_mem_req_fifo.sv
// Request FIFO: drops pushes while full (flagged on overflow_o) and registers
// almost-full from the post-update occupancy.
module ccis_host_mem_req_fifo #(
    parameter int unsigned WIDTH          = 8,
    parameter int unsigned DEPTH          = 16,
    parameter int unsigned ALM_FULL_SLACK = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             empty_o,
    output logic             alm_full_o,
    output logic             overflow_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] store_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             alm_full_q;
    logic             full, do_push, do_pop;

    assign full       = (cnt_q == CNT_W'(DEPTH));
    assign empty_o    = (cnt_q == '0);
    assign do_push    = push_i && !full;
    assign do_pop     = pop_i && !empty_o;
    assign overflow_o = push_i && full;
    assign data_o     = store_q[rd_ptr_q];
    assign alm_full_o = alm_full_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            alm_full_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            alm_full_q <= (cnt_d >= CNT_W'(DEPTH - ALM_FULL_SLACK));
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) store_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/ccis_host_mem_responder.sv
// CCI-S host memory model: in-order c0 read / c1 write responses from on-chip memory.
// Optional interrupt responses enabled by defining CCIS_HOST_MEM_INTR_EN.
module ccis_host_mem_responder
    import ccis_host_mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
    parameter int unsigned READ_LATENCY   = DEFAULT_READ_LATENCY,
    parameter int unsigned FIFO_DEPTH     = DEFAULT_FIFO_DEPTH,
    parameter int unsigned ALM_FULL_SLACK = DEFAULT_ALM_FULL_SLACK
) (
    input  logic           clk,
    input  logic           reset,
    input  t_if_ccis_c0_Tx c0Tx,
    input  t_if_ccis_c1_Tx c1Tx,
    output logic           c0TxAlmFull,
    output logic           c1TxAlmFull,
    output t_if_ccis_c0_Rx c0Rx,
    output t_if_ccis_c1_Rx c1Rx,
    input  logic           rsp_stall,
    output logic [1:0]     err_overflow
);

    localparam int unsigned MEM_DEPTH = 1 << ADDR_WIDTH;

    t_mem_line      mem [MEM_DEPTH];
    t_read_req      rd_push_entry, rd_head;
    t_write_req     wr_push_entry, wr_head;
    logic           rd_empty, wr_empty, rd_ovf, wr_ovf;
    logic           rd_pop, wr_pop;
    logic [ADDR_WIDTH-1:0] rd_idx, wr_idx;
    t_rd_pipe       pipe_q [READ_LATENCY];
    t_if_ccis_c0_Rx c0Rx_q;
    t_if_ccis_c1_Rx c1Rx_q;
    logic [1:0]     err_q;
    logic           intr_fire, intr_ovf;

    assign rd_push_entry = '{addr: c0Tx.hdr.addr, mdata: c0Tx.hdr.mdata};
    assign wr_push_entry = '{addr: c1Tx.hdr.addr, mdata: c1Tx.hdr.mdata, data: c1Tx.data};

    ccis_host_mem_req_fifo #(
        .WIDTH          ($bits(t_read_req)),
        .DEPTH          (FIFO_DEPTH),
        .ALM_FULL_SLACK (ALM_FULL_SLACK)
    ) u_rd_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_i     (c0Tx.rdValid),
        .data_i     (rd_push_entry),
        .pop_i      (rd_pop),
        .data_o     (rd_head),
        .empty_o    (rd_empty),
        .alm_full_o (c0TxAlmFull),
        .overflow_o (rd_ovf)
    );

    ccis_host_mem_req_fifo #(
        .WIDTH          ($bits(t_write_req)),
        .DEPTH          (FIFO_DEPTH),
        .ALM_FULL_SLACK (ALM_FULL_SLACK)
    ) u_wr_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_i     (c1Tx.wrValid),
        .data_i     (wr_push_entry),
        .pop_i      (wr_pop),
        .data_o     (wr_head),
        .empty_o    (wr_empty),
        .alm_full_o (c1TxAlmFull),
        .overflow_o (wr_ovf)
    );

    // Pops are held off during reset so discarded requests never touch memory.
    assign rd_pop = !reset && !rsp_stall && !rd_empty;
    assign wr_pop = !reset && !rsp_stall && !wr_empty;
    assign rd_idx = rd_head.addr[ADDR_WIDTH-1:0];
    assign wr_idx = wr_head.addr[ADDR_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (wr_pop) mem[wr_idx] <= wr_head.data;
    end

    // Stage 0 samples memory with a non-blocking read, giving read-first on collisions.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < READ_LATENCY; i++) pipe_q[i].valid <= 1'b0;
        end else begin
            pipe_q[0].valid <= rd_pop;
            pipe_q[0].mdata <= rd_head.mdata;
            pipe_q[0].data  <= mem[rd_idx];
            for (int unsigned i = 1; i < READ_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

`ifdef CCIS_HOST_MEM_INTR_EN
    logic       intr_s1_q;
    logic [3:0] intr_pend_q, intr_pend_d;
    logic [4:0] intr_sum;

    always_comb begin
        intr_fire   = (intr_s1_q || (intr_pend_q != '0)) && !wr_pop;
        intr_sum    = {1'b0, intr_pend_q} + {4'b0, intr_s1_q} - {4'b0, intr_fire};
        intr_ovf    = (intr_sum > 5'd15);
        intr_pend_d = intr_ovf ? 4'hF : intr_sum[3:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            intr_s1_q   <= 1'b0;
            intr_pend_q <= '0;
        end else begin
            intr_s1_q   <= c1Tx.intrValid;
            intr_pend_q <= intr_pend_d;
        end
    end
`else
    assign intr_fire = 1'b0;
    assign intr_ovf  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            c0Rx_q <= '0;
            c1Rx_q <= '0;
            err_q  <= '0;
        end else begin
            c0Rx_q           <= '0;
            c0Rx_q.rdValid   <= pipe_q[READ_LATENCY-1].valid;
            c0Rx_q.hdr.mdata <= pipe_q[READ_LATENCY-1].mdata;
            c0Rx_q.data      <= pipe_q[READ_LATENCY-1].data;
            c1Rx_q           <= '0;
            c1Rx_q.wrValid   <= wr_pop;
            c1Rx_q.hdr.mdata <= wr_head.mdata;
            c1Rx_q.intrValid <= intr_fire;
            err_q            <= err_q | {wr_ovf | intr_ovf, rd_ovf};
        end
    end

    assign c0Rx         = c0Rx_q;
    assign c1Rx         = c1Rx_q;
    assign err_overflow = err_q;

endmodule
